// File: rtl/nibble_add_seq.sv
// Multi-cycle W-bit adder built on one shared 4-bit ripple slice; one nibble per cycle, LSB first.
// Optional subtract mode is enabled by defining NIBBLE_ADD_SUB_EN (adds input port "sub").

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic                   sub,
`endif
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES:0]     sum
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    if (NIBBLES < 2 || NIBBLES > 16) begin : g_param_check
        $error("nibble_add_seq: NIBBLES must be in 2..16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            sub_reg;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [W:0]      sum_reg;

    logic            accept;
    logic            step;
    logic            last;
    logic            sub_in;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      b_eff;
    logic [3:0]      slice_sum;
    logic [4:0]      c;

`ifdef NIBBLE_ADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign last = (idx == IW'(NIBBLES - 1));

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    accept   = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Mux the current nibble out of the operand registers into the shared slice.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                a_nib = a_reg[4*i +: 4];
                b_nib = b_reg[4*i +: 4];
            end
        end
    end

    // Subtraction is a + ~b + 1: the +1 comes from the carry register seeded at accept.
    assign b_eff = b_nib ^ {4{sub_reg}};
    assign c[0]  = carry;

    for (genvar g = 0; g < 4; g++) begin : g_slice
        full_adder u_fa (
            .a    (a_nib[g]),
            .b    (b_eff[g]),
            .cin  (c[g]),
            .s    (slice_sum[g]),
            .cout (c[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
            carry   <= 1'b0;
            idx     <= '0;
            sum_reg <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_reg   <= a;
                b_reg   <= b;
                sub_reg <= sub_in;
                carry   <= sub_in;
                idx     <= '0;
            end
            if (step) begin
                carry <= c[4];
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx == IW'(i)) begin
                        sum_reg[4*i +: 4] <= slice_sum;
                    end
                end
                if (last) begin
                    sum_reg[W] <= c[4];
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);
    assign sum  = sum_reg;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed and table-driven bench for nibble_add_seq with NIBBLES=4 (16-bit operands).
// Subtract vectors and random sub ops are included when NIBBLE_ADD_SUB_EN is defined.

module tb_nibble_add_seq;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
    localparam int LAT     = NIBBLES + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy;
    logic         done;
    logic [W:0]   sum;
`ifdef NIBBLE_ADD_SUB_EN
    logic         sub_i;
`endif

    int checks   = 0;
    int failures = 0;

    nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef NIBBLE_ADD_SUB_EN
        .sub   (sub_i),
`endif
        .a     (a_i),
        .b     (b_i),
        .busy  (busy),
        .done  (done),
        .sum   (sum)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W:0]   exp;
    } vec_t;

    vec_t vecs[$];

    logic [W:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
        logic [W-1:0] diff;
        if (s) begin
            diff = x - y;
            return {(x >= y), diff};
        end
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Issue one op from IDLE; return the sum at done, edges from acceptance to done, busy count.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         output logic [W:0] res, output int lat, output int busy_cnt);
        @(negedge clk);
        a_i   = x;
        b_i   = y;
        start = 1'b1;
`ifdef NIBBLE_ADD_SUB_EN
        sub_i = s;
`endif
        @(negedge clk);
        start    = 1'b0;
        a_i      = W'($urandom);
        b_i      = W'($urandom);
`ifdef NIBBLE_ADD_SUB_EN
        sub_i    = ~s;
`endif
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end
        res = sum;
    endtask

    task automatic run_checked(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic s);
        logic [W:0] res;
        logic [W:0] exp;
        int         lat;
        int         bc;
        exp_q.push_back(ref_model(x, y, s));
        do_op(x, y, s, res, lat, bc);
        exp = exp_q.pop_front();
        check({tag, "_sum"}, 32'(res), 32'(exp));
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(LAT));
        @(negedge clk);
        check({tag, "_idle_done"}, {31'b0, done}, 32'd0);
        check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_sum_hold"}, 32'(sum), 32'(exp));
    endtask

    initial begin
        logic [W:0] res;
        int         lat;
        int         bc;
        int         guard;
        int         seen_done;

        rst   = 1'b1;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
`ifdef NIBBLE_ADD_SUB_EN
        sub_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: nothing moves for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_idle_busy", {31'b0, busy}, 32'd0);
            check("reset_idle_done", {31'b0, done}, 32'd0);
            check("reset_idle_sum", 32'(sum), 32'd0);
        end

        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 17'h05555});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 17'h10000});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 17'h00000});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 17'h10000});
        vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 17'h01000});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 17'h08000});
        vecs.push_back('{16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF});
`ifdef NIBBLE_ADD_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b1, 17'h0FFFE});
        vecs.push_back('{16'h0007, 16'h0005, 1'b1, 17'h10002});
        vecs.push_back('{16'h1234, 16'h1234, 1'b1, 17'h10000});
        vecs.push_back('{16'h0000, 16'hFFFF, 1'b1, 17'h00001});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, res, lat, bc);
            check($sformatf("vec%0d_sum", i), 32'(res), 32'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(LAT));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
            check($sformatf("vec%0d_sum_hold", i), 32'(sum), 32'(vecs[i].exp));
        end

        // start held high through RUN/DONE with changing operands: ignored until IDLE.
        @(negedge clk);
        a_i   = 16'h1234;
        b_i   = 16'h4321;
        start = 1'b1;
`ifdef NIBBLE_ADD_SUB_EN
        sub_i = 1'b0;
`endif
        guard = 0;
        do begin
            @(negedge clk);
            a_i = W'($urandom);
            b_i = W'($urandom);
            guard++;
        end while (!done && guard < 20);
        check("busy_ignore_latency", 32'(guard), 32'(LAT));
        check("busy_ignore_sum", 32'(sum), 32'h05555);
        a_i = 16'h1111;
        b_i = 16'h2222;
        @(negedge clk);
        check("revisit_idle_busy", {31'b0, busy}, 32'd0);
        check("revisit_idle_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        check("reaccept_busy", {31'b0, busy}, 32'd1);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("reaccept_latency", 32'(lat), 32'(LAT));
        check("reaccept_sum", 32'(sum), 32'h03333);

        // Reset on the 2nd RUN cycle aborts the op with no done pulse.
        @(negedge clk);
        a_i   = 16'hAAAA;
        b_i   = 16'h5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_run1_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        run_checked("after_abort", 16'hAAAA, 16'h5555, 1'b0);

        // Random operations against the reference model.
`ifdef NIBBLE_ADD_SUB_EN
        for (int i = 0; i < 1000; i++) begin
            run_checked("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
`else
        for (int i = 0; i < 200; i++) begin
            run_checked("rand", W'($urandom), W'($urandom), 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Multi-cycle controller that adds two 4*NIBBLES-bit operands using one shared 4-bit ripple slice.
- The slice is built from the team's full_adder cells, with carry-in, and is processed one nibble per cycle, LSB first.
- Sits beside the nibble adder datapath: it latches the operands, sequences the nibble index, carries the inter-nibble carry in a register, and assembles the result.
- Trades latency for area where a full-width adder is not affordable.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  4*NIBBLES  operand A; captured on accepted start.
- b  input  4*NIBBLES  operand B; captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; sum is valid in this cycle.
- sum  output  4*NIBBLES+1  result; the MSB is the final carry-out.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry register=0, nibble index=0, operand registers=0.
- Reset asserted mid-operation: the operation is aborted, and every register returns to its reset value on that edge. No done pulse is produced.
- States:
  - IDLE: waiting for start.
  - RUN: one nibble is added per cycle.
  - DONE: done=1 for exactly one cycle.
- IDLE -> RUN, when start=1:
  - a_reg<=a, b_reg<=b, carry<=0, idx<=0.
  - sum is not cleared at this point.
  - a and b need not be held after this edge.
- RUN, each cycle:
  - The slice adds a_reg[4*idx+3:4*idx], b_reg[4*idx+3:4*idx] and carry.
  - sum[4*idx+3:4*idx] <= slice sum; carry <= slice carry-out.
  - If idx != NIBBLES-1: idx <= idx+1, and the block stays in RUN.
  - If idx == NIBBLES-1: sum[4*NIBBLES] <= slice carry-out, and state <= DONE.
- DONE: done=1 and busy=1; next cycle go to IDLE, with done=0 and busy=0.
- Latency:
  - start sampled at edge t gives done high in the cycle after edge t+NIBBLES.
  - Total NIBBLES+1 cycles from acceptance to the done pulse.
  - Throughput: one operation per NIBBLES+2 cycles (IDLE must be revisited before the next start).
- start while busy=1 (RUN or DONE): ignored, not queued, and has no effect on the operation in flight.
- start held high continuously: a new operation is accepted on every IDLE cycle.
- sum stability:
  - sum is valid while done=1 and stays stable through IDLE until the next accepted start.
  - During RUN, nibbles above idx still hold the previous result; that value is undefined for consumers.
- Arithmetic:
  - Unsigned; sum = a + b exactly, W+1 bits, no overflow possible.
  - Carry propagates only through the carry register, never combinationally across nibbles.
- Index width: enough bits for NIBBLES-1; it never wraps past NIBBLES-1.

Optional Feature:
- Macro: NIBBLE_ADD_SUB_EN.
- When defined, the block gains an input port "sub" (1 bit), captured with a and b on an accepted start.
- If captured sub=1:
  - The slice uses ~b_reg nibbles, and the carry register is initialised to 1 instead of 0.
  - sum[W-1:0] = (a - b) mod 2^W.
  - sum[W] = 1 means no borrow (a >= b); sum[W] = 0 means borrow.
- If captured sub=0, behaviour is identical to the base block.
- When not defined, the port is absent and only addition exists. Timing is identical in both builds.

Test Plan:
- Reset, then idle with start=0 for 10 cycles -> busy=0, done=0, sum=0 throughout.
- NIBBLES=4, a=16'h1234, b=16'h4321, start one cycle -> busy=1 for 5 cycles, done pulses once exactly 5 cycles after acceptance, sum=17'h05555.
- Full carry ripple: a=16'hFFFF, b=16'h0001 -> sum=17'h10000 at done; then a=16'hFFFF, b=16'hFFFF -> sum=17'h1FFFE.
- start re-asserted on every cycle of RUN with different operands -> ignored; first result unchanged. Next acceptance occurs on the first IDLE cycle after DONE.
- rst asserted on the 2nd RUN cycle of a=16'hAAAA, b=16'h5555 -> next cycle busy=0, done=0, sum=0; no done pulse afterwards. A fresh start then produces the correct result, 17'h0FFFF.
- NIBBLE_ADD_SUB_EN defined, sub=1:
  - a=16'h0005, b=16'h0007 -> sum=17'h0FFFE (borrow).
  - a=16'h0007, b=16'h0005 -> sum=17'h10002.
  - Random a/b/sub, 1000 operations -> compare against a reference model.
